// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and default constants for the SRAM memory-stage controller
package sram_ctrl_pkg;

    localparam int unsigned DEF_MEM_BASE    = 1024;
    localparam int unsigned DEF_SRAM_AW     = 18;
    localparam int unsigned DEF_WAIT_CYCLES = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACC_LO = 3'd1,
        ACC_HI = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - 32-bit load/store to two 16-bit async SRAM accesses with wait states
// Optional range check with sticky addr_err output: define SRAM_MEM_RANGE_CHECK_EN.
module sram_mem_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BASE    = DEF_MEM_BASE,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
`ifdef SRAM_MEM_RANGE_CHECK_EN
    ,
    output logic               addr_err
`endif
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e             r_state;
    state_e             w_state_next;
    op_e                r_op;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_read_data;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [15:0]        r_dq_out;
    logic               r_dq_oe;
    logic               r_we_n;
    logic               r_oe_n;

    logic               w_req;
    op_e                w_op_in;
    op_e                w_src_op;
    logic [31:0]        w_src_addr;
    logic [31:0]        w_src_wdata;
    logic               w_src_err;
    logic               w_cur_err;
    logic [SRAM_AW-1:0] w_half_lo;
    logic [SRAM_AW-1:0] w_half_hi;

    logic [SRAM_AW-1:0] w_addr_nx;
    logic [15:0]        w_dq_out_nx;
    logic               w_dq_oe_nx;
    logic               w_we_n_nx;
    logic               w_oe_n_nx;

    assign w_req   = rd_en | wr_en;
    assign w_op_in = wr_en ? OP_WRITE : OP_READ;

    // Pin values are registered, so they are computed from the request that the next state will serve:
    // the live inputs when leaving IDLE, the latched request afterwards.
    assign w_src_op    = (r_state == IDLE) ? w_op_in    : r_op;
    assign w_src_addr  = (r_state == IDLE) ? address    : r_addr;
    assign w_src_wdata = (r_state == IDLE) ? write_data : r_wdata;

    assign w_half_lo = SRAM_AW'(((w_src_addr - MEM_BASE) >> 2) << 1);
    assign w_half_hi = w_half_lo | SRAM_AW'(1);

`ifdef SRAM_MEM_RANGE_CHECK_EN
    logic w_in_err;
    logic r_acc_err;
    logic r_addr_err;

    assign w_in_err  = (address < MEM_BASE) ||
                       (((address - MEM_BASE) >> 2) >= (32'd1 << (SRAM_AW - 1)));
    assign w_src_err = (r_state == IDLE) ? w_in_err : r_acc_err;
    assign w_cur_err = r_acc_err;
    assign addr_err  = r_addr_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_err  <= 1'b0;
            r_addr_err <= 1'b0;
        end else if (r_state == IDLE && w_req) begin
            r_acc_err <= w_in_err;
            if (w_in_err) begin
                r_addr_err <= 1'b1;
            end
        end
    end
`else
    assign w_src_err = 1'b0;
    assign w_cur_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_req ? ACC_LO : IDLE;
            ACC_LO:  w_state_next = ACC_HI;
            ACC_HI:  w_state_next = (WAIT_CYCLES > 0) ? WAIT : DONE;
            WAIT:    w_state_next = (r_cnt == CNT_LAST) ? DONE : WAIT;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ready       = ((r_state == IDLE) && !w_req) || (r_state == DONE);
        w_addr_nx   = r_sram_addr;
        w_dq_out_nx = r_dq_out;
        w_dq_oe_nx  = 1'b0;
        w_we_n_nx   = 1'b1;
        w_oe_n_nx   = 1'b1;
        if (w_state_next == ACC_LO || w_state_next == ACC_HI) begin
            w_addr_nx = (w_state_next == ACC_LO) ? w_half_lo : w_half_hi;
            if (w_src_op == OP_WRITE) begin
                w_dq_out_nx = (w_state_next == ACC_LO) ? w_src_wdata[15:0] : w_src_wdata[31:16];
                if (!w_src_err) begin
                    w_dq_oe_nx = 1'b1;
                    w_we_n_nx  = 1'b0;
                end
            end else if (!w_src_err) begin
                w_oe_n_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= OP_READ;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_op    <= w_op_in;
                r_addr  <= address;
                r_wdata <= write_data;
            end
            r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
            // Each read half is sampled on the edge that ends its access cycle; flagged accesses return 0.
            if (r_op == OP_READ && r_state == ACC_LO) begin
                r_read_data[15:0] <= w_cur_err ? 16'h0000 : sram_dq_in;
            end
            if (r_op == OP_READ && r_state == ACC_HI) begin
                r_read_data[31:16] <= w_cur_err ? 16'h0000 : sram_dq_in;
            end
            r_sram_addr <= w_addr_nx;
            r_dq_out    <= w_dq_out_nx;
            r_dq_oe     <= w_dq_oe_nx;
            r_we_n      <= w_we_n_nx;
            r_oe_n      <= w_oe_n_nx;
        end
    end

    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;
    assign sram_oe_n   = r_oe_n;

endmodule
